// File: rtl/userio_pkg.sv
// rtl/userio_pkg.sv - shared FSM state and DB15 button-index definitions
package userio_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SAMPLE,
    ST_CLOCK,
    ST_COMMIT,
    ST_GAP
  } db15_state_e;

  localparam int DB15_R     = 0;
  localparam int DB15_L     = 1;
  localparam int DB15_D     = 2;
  localparam int DB15_U     = 3;
  localparam int DB15_A     = 4;
  localparam int DB15_B     = 5;
  localparam int DB15_C     = 6;
  localparam int DB15_X     = 7;
  localparam int DB15_Y     = 8;
  localparam int DB15_Z     = 9;
  localparam int DB15_START = 10;
  localparam int DB15_MODE  = 11;

endpackage

// File: rtl/db15_tick_gen.sv
// rtl/db15_tick_gen.sv - CLK_DIV bit-phase divider with terminal-count tick and sync clear
module db15_tick_gen #(
  parameter int CLK_DIV = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int             W    = $clog2(CLK_DIV);
  localparam logic [W-1:0]   TERM = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == TERM);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/userio_db15_scanner.sv
// rtl/userio_db15_scanner.sv - DB15 adapter poller/deserialiser; DB15_DEBOUNCE_EN adds 2-frame debounce
module userio_db15_scanner
  import userio_pkg::*;
#(
  parameter int CLK_DIV   = 24,
  parameter int GAP_TICKS = 64,
  parameter int BITS      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done,
  output logic        connected
);

  localparam int              NB       = 2 * BITS;
  localparam logic [4:0]      LAST_IDX = 5'(NB - 1);
  localparam int              GW       = $clog2(GAP_TICKS + 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_TICKS - 1);

  db15_state_e   state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [4:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [NB-1:0] raw_q, raw_d;
  logic [NB-1:0] btn_q, btn_d;
  logic          joy_clk_q, joy_clk_d;
  logic          joy_load_q, joy_load_d;
  logic          frame_done_q, frame_done_d;
  logic          connected_q, connected_d;
  logic          tick, div_clear;
`ifdef DB15_DEBOUNCE_EN
  logic [NB-1:0] hist_q, hist_d;
  logic [NB-1:0] match;
`endif

  db15_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      sync_q       <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      raw_q        <= '0;
      btn_q        <= '0;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
      frame_done_q <= 1'b0;
      connected_q  <= 1'b0;
`ifdef DB15_DEBOUNCE_EN
      hist_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      raw_q        <= raw_d;
      btn_q        <= btn_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
      connected_q  <= connected_d;
`ifdef DB15_DEBOUNCE_EN
      hist_q       <= hist_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    raw_d   = raw_q;
    sync_d  = {sync_q[0], joy_data};
    case (state_q)
      ST_LOAD: if (tick) begin
        state_d = ST_SAMPLE;
        idx_d   = '0;
      end
      // Sampling on the tick puts the capture CLK_DIV-2 clks after the joy_clk fall.
      ST_SAMPLE: if (tick) begin
        raw_d[idx_q] = ~sync_q[1];
        state_d      = ST_CLOCK;
      end
      ST_CLOCK: if (tick) begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SAMPLE;
          idx_d   = idx_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: if (tick) begin
        if (gap_q == GAP_LAST) state_d = ST_LOAD;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Adapter strobes lag the state by one clk so they come straight from flops.
  always_comb begin
    div_clear    = (state_q == ST_COMMIT);
    joy_load_d   = (state_q != ST_LOAD);
    joy_clk_d    = (state_q == ST_CLOCK);
    frame_done_d = (state_q == ST_COMMIT);
    connected_d  = connected_q;
    btn_d        = btn_q;
`ifdef DB15_DEBOUNCE_EN
    hist_d       = hist_q;
    match        = ~(raw_q ^ hist_q);
`endif
    if (state_q == ST_COMMIT) begin
      if (&raw_q) begin
        connected_d = 1'b0;
        btn_d       = '0;
`ifdef DB15_DEBOUNCE_EN
        hist_d      = '0;
`endif
      end else begin
        connected_d = 1'b1;
`ifdef DB15_DEBOUNCE_EN
        btn_d       = (raw_q & match) | (btn_q & ~match);
        hist_d      = raw_q;
`else
        btn_d       = raw_q;
`endif
      end
    end
  end

  always_comb begin
    joystick1               = '0;
    joystick2               = '0;
    joystick1[BITS-1:0]     = btn_q[BITS-1:0];
    joystick2[BITS-1:0]     = btn_q[NB-1:BITS];
    joy_clk                 = joy_clk_q;
    joy_load                = joy_load_q;
    frame_done              = frame_done_q;
    connected               = connected_q;
  end

endmodule
